// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port 32x32 data RAM between the CPU MEM
// stage (m0, default priority) and the bus/debug side (m1).
//
// Every access is issued in one cycle and answered in the next. The winner
// drives ram_* during its issue cycle. In the following response cycle it
// sees ack, plus rdata for reads and err for misaligned addresses.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   mX_req        request, held by the master until mX_ack
//   mX_we         1 = write, 0 = read
//   mX_addr       byte address (RAM decodes [6:2])
//   mX_wdata      write data
//   mX_rdata      read data, valid with mX_ack, 0 otherwise
//   mX_ack        one-cycle completion pulse
//   mX_err        misaligned-address flag, valid with mX_ack
//   ram_ena       RAM enable
//   ram_wena      RAM write enable
//   ram_addr      RAM address (winner pass-through)
//   ram_wdata     RAM write data (winner pass-through)
//   ram_rdata     RAM read data, one cycle after ram_ena
//   busy          high in every response cycle

module dmem_arbiter #(
    parameter int STARVE_LIM = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,

    output logic        ram_ena,
    output logic        ram_wena,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,

    output logic        busy
);

    localparam logic [CNT_W-1:0] LIM     = CNT_W'(STARVE_LIM);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Response-owner flags and attributes of the access being answered.
    logic             pend0;
    logic             pend1;
    logic             pend_we;
    logic             pend_err;
    logic [CNT_W-1:0] starve_cnt;

    logic             elig0;
    logic             elig1;
    logic             starved;
    logic             grant0;
    logic             grant1;
    logic             any_grant;
    logic             win_we;
    logic             win_mis;
    logic [31:0]      win_addr;
    logic [31:0]      win_wdata;

    // A master in its own ack cycle is not eligible. A req still high there
    // belongs to the completed access, so the master cannot be issued twice.
    always_comb begin
        elig0   = m0_req & ~pend0;
        elig1   = m1_req & ~pend1;
        starved = (starve_cnt >= LIM);
    end

    // No grant while reset is asserted. This keeps the RAM quiet
    // immediately, even if the masters still hold req high.
    always_comb begin
        grant1    = ~rst & elig1 & (~elig0 | starved);
        grant0    = ~rst & elig0 & ~grant1;
        any_grant = grant0 | grant1;
    end

    // With no winner, m0's inputs pass through with ram_ena low.
    always_comb begin
        if (grant1) begin
            win_we    = m1_we;
            win_addr  = m1_addr;
            win_wdata = m1_wdata;
        end else begin
            win_we    = m0_we;
            win_addr  = m0_addr;
            win_wdata = m0_wdata;
        end
        win_mis = (win_addr[1:0] != 2'b00);
    end

    // A misaligned winner is still granted and answered, but it never
    // reaches the RAM.
    always_comb begin
        ram_ena   = any_grant & ~win_mis;
        ram_wena  = ram_ena & win_we;
        ram_addr  = win_addr;
        ram_wdata = win_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend0      <= 1'b0;
            pend1      <= 1'b0;
            pend_we    <= 1'b0;
            pend_err   <= 1'b0;
            starve_cnt <= '0;
        end else begin
            pend0 <= grant0;
            pend1 <= grant1;
            if (any_grant) begin
                pend_we  <= win_we;
                pend_err <= win_mis;
            end
            // In m1's ack cycle, elig1 is low, so the counter holds.
            if (grant1 || !m1_req) begin
                starve_cnt <= '0;
            end else if (elig1 && starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // Read data is gated so each rdata output is zero outside its own
    // read-response cycle.
    logic rd_ok;

    always_comb begin
        rd_ok    = ~pend_we & ~pend_err;
        m0_ack   = pend0;
        m1_ack   = pend1;
        m0_err   = pend0 & pend_err;
        m1_err   = pend1 & pend_err;
        m0_rdata = (pend0 & rd_ok) ? ram_rdata : 32'h0;
        m1_rdata = (pend1 & rd_ok) ? ram_rdata : 32'h0;
        busy     = pend0 | pend1;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a
// transaction-level model with a shadow memory.

module tb_dmem_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        ram_ena, ram_wena, busy;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIM(LIM), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .m1_err(m1_err),
        .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    // RAM model: 32 words, synchronous read.
    logic [31:0] mem [32] = '{default: 32'h0};

    always @(posedge clk) begin
        if (ram_ena) begin
            if (ram_wena) mem[ram_addr[6:2]] <= ram_wdata;
            ram_rdata <= mem[ram_addr[6:2]];
        end
    end

    // Transaction model. owner: 0 none, 1 m0, 2 m1 in the response cycle.
    logic [31:0] shadow [32] = '{default: 32'h0};
    int          owner;
    int          wait1;
    logic        r_we, r_err;
    logic [31:0] r_data;

    int          win;
    logic        e0, e1, w_we, w_mis;
    logic [31:0] w_addr, w_data;
    logic        x_ena, x_wena;

    always_comb begin
        e0 = m0_req && owner != 1;
        e1 = m1_req && owner != 2;
        win = 0;
        if (!rst) begin
            if (e1 && (!e0 || wait1 >= LIM)) win = 2;
            else if (e0) win = 1;
        end
        w_we   = (win == 2) ? m1_we : m0_we;
        w_addr = (win == 2) ? m1_addr : m0_addr;
        w_data = (win == 2) ? m1_wdata : m0_wdata;
        w_mis  = w_addr[1:0] != 2'b00;
        x_ena  = win != 0 && !w_mis;
        x_wena = x_ena && w_we;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= 0;
            wait1 <= 0;
            r_we <= 1'b0;
            r_err <= 1'b0;
            r_data <= 32'h0;
        end else begin
            owner <= win;
            if (win == 2 || !m1_req) wait1 <= 0;
            else if (e1) wait1 <= (wait1 < 15) ? wait1 + 1 : 15;
            if (win != 0) begin
                r_we <= w_we;
                r_err <= w_mis;
                r_data <= (!w_we && !w_mis) ? shadow[w_addr[6:2]] : 32'h0;
                if (w_we && !w_mis) shadow[w_addr[6:2]] <= w_data;
            end
        end
    end

    logic        x_ack0, x_ack1, x_err0, x_err1, x_busy;
    logic [31:0] x_rd0, x_rd1;

    always_comb begin
        x_ack0 = owner == 1;
        x_ack1 = owner == 2;
        x_err0 = x_ack0 && r_err;
        x_err1 = x_ack1 && r_err;
        x_rd0  = x_ack0 ? r_data : 32'h0;
        x_rd1  = x_ack1 ? r_data : 32'h0;
        x_busy = owner != 0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #12;
        checks++;
        if ({m0_ack, m1_ack, m0_err, m1_err, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {m0_ack, m1_ack, m0_err, m1_err, busy});
        end
        checks++;
        if ({m0_rdata, m1_rdata} !== 64'h0 || ram_ena !== 1'b0) begin
            errors++;
            $display("FAIL reset_data rd0 %h rd1 %h ena %b want 0",
                     m0_rdata, m1_rdata, ram_ena);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_m0_write_read();
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (ram_ena !== 1'b1 || ram_wena !== 1'b1) begin
            errors++;
            $display("FAIL t1_wr_issue ena %b wena %b want 1 1",
                     ram_ena, ram_wena);
        end
        step();
        checks++;
        if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL t1_wr_ack ack %b err %b m1 %b want 1 0 0",
                     m0_ack, m0_err, m1_ack);
        end
        m0_we = 0;
        #1;
        checks++;
        if (ram_ena !== 1'b0) begin
            errors++;
            $display("FAIL t1_ack_cycle_issue ena %b want 0", ram_ena);
        end
        step();
        checks++;
        if (ram_ena !== 1'b1 || ram_wena !== 1'b0) begin
            errors++;
            $display("FAIL t1_rd_issue ena %b wena %b want 1 0",
                     ram_ena, ram_wena);
        end
        step();
        m0_req = 0;
        checks++;
        if (m0_ack !== 1'b1 || m0_rdata !== 32'hDEADBEEF
            || m0_err !== 1'b0 || m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL t1_rd_ack ack %b rd %h err %b want 1 deadbeef 0",
                     m0_ack, m0_rdata, m0_err);
        end
        step();
    endtask

    task automatic test_both_read();
        m0_req = 1; m0_we = 0; m0_addr = 32'h04;
        m1_req = 1; m1_we = 0; m1_addr = 32'h08;
        #1;
        checks++;
        if (ram_ena !== 1'b1 || ram_addr !== 32'h04) begin
            errors++;
            $display("FAIL t2_first ena %b addr %h want 1 4",
                     ram_ena, ram_addr);
        end
        step();
        m0_req = 0;
        #1;
        checks++;
        if (m0_ack !== 1'b1 || busy !== 1'b1 || m1_ack !== 1'b0
            || m0_rdata !== x_rd0 || ram_addr !== 32'h08 || ram_ena !== 1'b1) begin
            errors++;
            $display("FAIL t2_second ack0 %b busy %b addr %h rd %h want 1 1 8 %h",
                     m0_ack, busy, ram_addr, m0_rdata, x_rd0);
        end
        step();
        m1_req = 0;
        checks++;
        if (m1_ack !== 1'b1 || busy !== 1'b1 || m0_ack !== 1'b0
            || m1_rdata !== x_rd1) begin
            errors++;
            $display("FAIL t2_m1_ack ack1 %b busy %b rd %h want 1 1 %h",
                     m1_ack, busy, m1_rdata, x_rd1);
        end
        step();
    endtask

    task automatic test_starvation();
        bit got1 = 0;
        bit got0 = 0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h00;
        m1_req = 1; m1_we = 0; m1_addr = 32'h0C;
        for (int i = 0; i < 2 * LIM + 2 && !got1; i++) begin
            step();
            checks++;
            if (m0_ack !== x_ack0 || m1_ack !== x_ack1) begin
                errors++;
                $display("FAIL t3_acks got %b%b want %b%b",
                         m0_ack, m1_ack, x_ack0, x_ack1);
            end
            if (m0_ack) m0_addr = {27'h0, 3'(i), 2'b00};
            if (m1_ack) got1 = 1;
        end
        checks++;
        if (!got1) begin
            errors++;
            $display("FAIL t3_m1_timeout m1 not served in %0d cycles",
                     2 * LIM + 2);
        end
        m1_req = 0;
        checks++;
        if (dut.starve_cnt !== 4'd0) begin
            errors++;
            $display("FAIL t3_cnt_clear got %0d want 0", dut.starve_cnt);
        end
        for (int i = 0; i < 3 && !got0; i++) begin
            step();
            if (m0_ack) got0 = 1;
        end
        checks++;
        if (!got0) begin
            errors++;
            $display("FAIL t3_m0_resume m0 got no ack after m1 grant");
        end
        idle();
        step();
    endtask

    task automatic test_misaligned();
        logic [31:0] prior;
        prior = shadow[1];
        m1_req = 1; m1_we = 1; m1_addr = 32'h06; m1_wdata = 32'h12345678;
        #1;
        checks++;
        if (ram_ena !== 1'b0 || ram_wena !== 1'b0) begin
            errors++;
            $display("FAIL t4_issue ena %b wena %b want 0 0",
                     ram_ena, ram_wena);
        end
        step();
        checks++;
        if (m1_ack !== 1'b1 || m1_err !== 1'b1 || m1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL t4_resp ack %b err %b rd %h want 1 1 0",
                     m1_ack, m1_err, m1_rdata);
        end
        m1_req = 0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h04;
        step();
        m0_req = 0;
        checks++;
        if (m0_ack !== 1'b1 || m0_rdata !== prior || m0_err !== 1'b0) begin
            errors++;
            $display("FAIL t4_readback ack %b rd %h want 1 %h",
                     m0_ack, m0_rdata, prior);
        end
        step();
    endtask

    task automatic test_reset_in_resp();
        bit stray = 0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        m1_req = 1; m1_we = 0; m1_addr = 32'h10;
        step();
        checks++;
        if (m0_ack !== 1'b1) begin
            errors++;
            $display("FAIL t5_pre ack %b want 1", m0_ack);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (m0_ack !== 1'b0 || ram_ena !== 1'b0 || busy !== 1'b0
            || dut.starve_cnt !== 4'd0) begin
            errors++;
            $display("FAIL t5_rst ack %b ena %b busy %b cnt %0d want 0",
                     m0_ack, ram_ena, busy, dut.starve_cnt);
        end
        idle();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (m0_ack || m1_ack) stray = 1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL t5_after stray ack got 1 want 0");
        end
    endtask

    task automatic test_alternate();
        logic [31:0] last_w;
        int          prev;
        int          now;
        last_w = shadow[8];
        prev = 0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h20;
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = $urandom;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (ram_ena !== 1'b1) begin
                errors++;
                $display("FAIL t6_ena cycle %0d got %b want 1", i, ram_ena);
            end
            step();
            now = m0_ack ? 1 : (m1_ack ? 2 : 0);
            checks++;
            if (now == 0 || now == prev || (m0_ack && m1_ack)) begin
                errors++;
                $display("FAIL t6_alt cycle %0d ack0 %b ack1 %b prev %0d",
                         i, m0_ack, m1_ack, prev);
            end
            prev = now;
            if (m0_ack) begin
                checks++;
                if (m0_rdata !== last_w) begin
                    errors++;
                    $display("FAIL t6_rd cycle %0d got %h want %h",
                             i, m0_rdata, last_w);
                end
            end
            if (m1_ack) begin
                last_w = m1_wdata;
                m1_wdata = $urandom;
            end
        end
        idle();
        step();
    endtask

    task automatic rand_req(output logic req, output logic we,
                            output logic [31:0] addr, output logic [31:0] wd);
        req  = ($urandom_range(0, 3) != 0);
        we   = $urandom_range(0, 1) != 0;
        addr = $urandom;
        if ($urandom_range(0, 7) != 0) addr[1:0] = 2'b00;
        wd   = $urandom;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (m0_ack !== x_ack0 || m1_ack !== x_ack1
                || m0_err !== x_err0 || m1_err !== x_err1
                || m0_rdata !== x_rd0 || m1_rdata !== x_rd1
                || busy !== x_busy || dut.starve_cnt !== 4'(wait1)) begin
                bad++;
                if (bad < 6)
                    $display("FAIL rnd_resp cyc %0d ack %b%b err %b%b rd %h/%h want %b%b %b%b %h/%h",
                             i, m0_ack, m1_ack, m0_err, m1_err,
                             m0_rdata, m1_rdata, x_ack0, x_ack1,
                             x_err0, x_err1, x_rd0, x_rd1);
            end
            if (!m0_req || m0_ack) rand_req(m0_req, m0_we, m0_addr, m0_wdata);
            if (!m1_req || m1_ack) rand_req(m1_req, m1_we, m1_addr, m1_wdata);
            #1;
            if (ram_ena !== x_ena || ram_wena !== x_wena
                || (x_ena && (ram_addr !== w_addr || ram_wdata !== w_data))) begin
                bad++;
                if (bad < 6)
                    $display("FAIL rnd_issue cyc %0d ena %b wena %b addr %h want %b %b %h",
                             i, ram_ena, ram_wena, ram_addr,
                             x_ena, x_wena, w_addr);
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rnd_total mismatching cycles %0d want 0", bad);
        end
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_m0_write_read();
        test_both_read();
        test_starvation();
        test_misaligned();
        test_reset_in_resp();
        test_alternate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
